// File: rtl/imem_loader_if.sv
// Loader bus: byte stream in (valid/ready), single-port
// instruction-memory word write out.
interface imem_loader_if #(
  parameter int unsigned ADDR_WIDTH = 10
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (
    input  in_data,
    input  in_valid,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport slave (
    output in_data,
    output in_valid,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: 16-bit LE word count then LE words,
// written one per cycle; holds the core in reset until done.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          core_rst,
  output logic          done,
  output logic          overflow,
  output logic [15:0]   words_loaded
);
  localparam logic [31:0] DEPTH = 32'd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    DONE
  } state_t;

  state_t state;
  state_t stateNxt;

  logic [15:0]           count;
  logic [15:0]           wordsSeen;
  logic [1:0]            byteIdx;
  logic [23:0]           wordBuf;
  logic                  lastPend;
  logic                  inReady;
  logic                  xfer;
  logic                  wordEnd;
  logic                  lastWord;
  logic                  room;
  logic                  startOk;
  logic                  weQ;
  logic [ADDR_WIDTH-1:0] addrQ;
  logic [31:0]           wdataQ;

  assign inReady = (state == LEN_LO)
                 | (state == LEN_HI)
                 | (state == DATA);
  assign xfer     = bus.in_valid & inReady;
  assign wordEnd  = (state == DATA) & xfer
                  & (byteIdx == 2'd3);
  assign lastWord = wordEnd
                  & ((wordsSeen + 16'd1) == count);
  assign room     = {16'd0, words_loaded} < DEPTH;
  assign startOk  = start
                  & ((state == IDLE) | (state == DONE));

  assign bus.in_ready   = inReady;
  assign bus.imem_we    = weQ;
  assign bus.imem_addr  = addrQ;
  assign bus.imem_wdata = wdataQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    unique case (state)
      IDLE: begin
        if (start) stateNxt = LEN_LO;
      end
      LEN_LO: begin
        if (bus.in_valid) stateNxt = LEN_HI;
      end
      LEN_HI: begin
        if (bus.in_valid) begin
          if ({bus.in_data, count[7:0]} == 16'd0)
            stateNxt = DONE;
          else
            stateNxt = DATA;
        end
      end
      DATA: begin
        if (lastPend) stateNxt = DONE;
      end
      DONE: begin
        if (start) stateNxt = LEN_LO;
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      weQ          <= 1'b0;
      addrQ        <= BASE;
      wdataQ       <= '0;
      core_rst     <= 1'b1;
      done         <= 1'b0;
      overflow     <= 1'b0;
      words_loaded <= '0;
      count        <= '0;
      wordsSeen    <= '0;
      byteIdx      <= '0;
      wordBuf      <= '0;
      lastPend     <= 1'b0;
    end else begin
      weQ      <= 1'b0;
      core_rst <= (stateNxt != DONE);
      done     <= (stateNxt == DONE);
      // address moves on the cycle after a write, pinned at the top word
      if (weQ && (addrQ != LAST))
        addrQ <= addrQ + ADDR_WIDTH'(1);
      if (startOk) begin
        addrQ        <= BASE;
        words_loaded <= '0;
        overflow     <= 1'b0;
        wordsSeen    <= '0;
        byteIdx      <= '0;
        lastPend     <= 1'b0;
      end
      if (xfer && (state == LEN_LO))
        count[7:0] <= bus.in_data;
      if (xfer && (state == LEN_HI))
        count[15:8] <= bus.in_data;
      if (xfer && (state == DATA)) begin
        byteIdx <= byteIdx + 2'd1;
        wordBuf <= {bus.in_data, wordBuf[23:8]};
      end
      if (wordEnd) begin
        wdataQ    <= {bus.in_data, wordBuf};
        wordsSeen <= wordsSeen + 16'd1;
        lastPend  <= lastWord;
        if (room) begin
          weQ          <= 1'b1;
          words_loaded <= words_loaded + 16'd1;
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: stream-level model of expected writes
// and status, checked every cycle on the active DUT.
module tb_imem_loader;
  localparam int INF = 32'h3fffffff;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       inValid = 1'b0;
  logic       useB = 1'b0;
  logic [7:0] inData = 8'h00;

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_WIDTH(10)) ifA ();
  imem_loader_if #(.ADDR_WIDTH(2))  ifB ();

  logic        coreRstA, doneA, ovfA;
  logic        coreRstB, doneB, ovfB;
  logic [15:0] wlA, wlB;

  assign ifA.in_data  = inData;
  assign ifA.in_valid = inValid & ~useB;
  assign ifB.in_data  = inData;
  assign ifB.in_valid = inValid & useB;

  imem_loader #(.ADDR_WIDTH(10), .BASE_ADDR(0)) dutA (
    .clk(clk), .rst(rst), .start(start & ~useB),
    .bus(ifA.master), .core_rst(coreRstA), .done(doneA),
    .overflow(ovfA), .words_loaded(wlA)
  );

  imem_loader #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dutB (
    .clk(clk), .rst(rst), .start(start & useB),
    .bus(ifB.master), .core_rst(coreRstB), .done(doneB),
    .overflow(ovfB), .words_loaded(wlB)
  );

  wire        mRdy     = useB ? ifB.in_ready : ifA.in_ready;
  wire        mWe      = useB ? ifB.imem_we : ifA.imem_we;
  wire [9:0]  mAddr    = useB ? {8'd0, ifB.imem_addr} : ifA.imem_addr;
  wire [31:0] mData    = useB ? ifB.imem_wdata : ifA.imem_wdata;
  wire        mCoreRst = useB ? coreRstB : coreRstA;
  wire        mDone    = useB ? doneB : doneA;
  wire        mOvf     = useB ? ovfB : ovfA;
  wire [15:0] mWl      = useB ? wlB : wlA;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t         q[$];
  int          cyc = 0;
  int          rdyOnAt = INF;
  int          doneAt = INF;
  int          wlExp = 0;
  int          nbyte = 0;
  int          cnt = 0;
  bit          armed = 1'b0;
  bit          idle = 1'b1;
  bit          busy = 1'b0;
  bit          ovfExp = 1'b0;
  logic [31:0] wordAsm = '0;
  int          total = 0;
  int          bad = 0;
  int          nWr = 0;
  logic [31:0] img [0:1023];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // stream-level model: byte n of a load is count (n<2) or
  // byte (n-2)%4 of word (n-2)/4
  initial forever begin : monitor
    int c;
    int w;
    int k;
    @(posedge clk);
    c = cyc;
    if (rst) begin
      armed = 1'b1; idle = 1'b1; busy = 1'b0;
      rdyOnAt = INF; doneAt = INF;
      wlExp = 0; ovfExp = 1'b0; nbyte = 0;
      q.delete();
    end else if (start && (idle || c >= doneAt)) begin
      idle = 1'b0; busy = 1'b1;
      rdyOnAt = c + 1; doneAt = INF;
      wlExp = 0; ovfExp = 1'b0; nbyte = 0;
    end else if (busy && inValid && mRdy) begin
      if (nbyte == 0) begin
        cnt = int'(inData);
      end else if (nbyte == 1) begin
        cnt = cnt + int'(inData) * 256;
        if (cnt == 0) begin
          busy = 1'b0; doneAt = c + 1;
        end
      end else begin
        w = (nbyte - 2) / 4;
        k = (nbyte - 2) % 4;
        wordAsm[8*k +: 8] = inData;
        if (k == 3) begin
          if (w < (useB ? 4 : 1024)) begin
            q.push_back('{w, wordAsm, c + 1});
            wlExp++;
          end else begin
            ovfExp = 1'b1;
          end
          if (w == cnt - 1) begin
            busy = 1'b0; doneAt = c + 2;
          end
        end
      end
      nbyte++;
    end
    cyc = c + 1;
  end

  initial forever begin : compare
    wr_t e;
    bit  weExp;
    @(negedge clk);
    if (armed) begin
      chk("in_ready", 32'(mRdy),
          32'(cyc >= rdyOnAt && cyc < doneAt));
      chk("done", 32'(mDone), 32'(cyc >= doneAt));
      chk("core_rst", 32'(mCoreRst), 32'(cyc < doneAt));
      chk("words_loaded", 32'(mWl), wlExp);
      chk("overflow", 32'(mOvf), 32'(ovfExp));
      weExp = (q.size() > 0) && (q[0].cyc <= cyc);
      chk("imem_we", 32'(mWe), 32'(weExp));
      if (mWe) begin
        img[mAddr] = mData;
        nWr++;
      end
      if (mWe && q.size() > 0) begin
        e = q.pop_front();
        chk("imem_addr", 32'(mAddr), e.addr);
        chk("imem_wdata", mData, e.data);
        chk("we_latency", cyc, e.cyc);
      end else if (weExp) begin
        void'(q.pop_front());
      end
    end
  end

  task automatic waitCyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulseStart();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk); rst = 1'b1;
    waitCyc(2);
    rst = 1'b0;
  endtask

  function automatic void mkLoad(input logic [31:0] w[$],
                                 output logic [7:0] b[$]);
    int n;
    n = w.size();
    b = {};
    b.push_back(8'(n));
    b.push_back(8'(n >> 8));
    foreach (w[i])
      for (int j = 0; j < 4; j++)
        b.push_back(w[i][8*j +: 8]);
  endfunction

  task automatic sendBytes(input logic [7:0] b[$], input bit rnd,
                           input int startAt);
    for (int i = 0; i < b.size(); i++) begin
      bit acc;
      int g;
      acc = 1'b0;
      g = 0;
      while (!acc) begin
        @(negedge clk);
        start   = (i == startAt) && (g == 0);
        inData  = b[i];
        inValid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        acc     = inValid && mRdy;
        g++;
        if (!acc && g > 300) begin
          total++; bad++;
          $display("FAIL stall: byte %0d not taken in 300 cycles", i);
          inValid = 1'b0; start = 1'b0;
          return;
        end
      end
    end
    @(negedge clk);
    inValid = 1'b0;
    start   = 1'b0;
  endtask

  logic [31:0] w[$];
  logic [7:0]  b[$];
  logic [7:0]  part[$];
  int          rc;
  int          dep;
  bit          nb;

  initial begin
    waitCyc(2);
    chk("rst_addr", 32'(mAddr), 0);
    chk("rst_wdata", mData, 0);
    chk("rst_we", 32'(mWe), 0);
    chk("rst_core_rst", 32'(mCoreRst), 1);
    chk("rst_ready", 32'(mRdy), 0);
    chk("rst_wl", 32'(mWl), 0);
    rst = 1'b0;
    waitCyc(2);

    // boot image from the two-instruction example
    b = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
          8'h93, 8'h00, 8'h10, 8'h00};
    nWr = 0;
    pulseStart();
    sendBytes(b, 1'b0, -1);
    waitCyc(3);
    chk("t1_w0", img[0], 32'h00000013);
    chk("t1_w1", img[1], 32'h00100093);
    chk("t1_nwr", nWr, 2);
    chk("t1_done", 32'(mDone), 1);
    chk("t1_core_rst", 32'(mCoreRst), 0);
    chk("t1_wl", 32'(mWl), 2);
    inData = 8'hff; inValid = 1'b1;
    waitCyc(4);
    inValid = 1'b0;
    chk("t1_stray_rdy", 32'(mRdy), 0);
    chk("t1_stray_nwr", nWr, 2);

    // zero-length load
    nWr = 0;
    pulseStart();
    sendBytes('{8'h00, 8'h00}, 1'b0, -1);
    waitCyc(3);
    chk("t2_nwr", nWr, 0);
    chk("t2_wl", 32'(mWl), 0);
    chk("t2_core_rst", 32'(mCoreRst), 0);

    // same image with a stuttering source
    img[0] = '0; img[1] = '0; nWr = 0;
    pulseStart();
    sendBytes(b, 1'b1, -1);
    waitCyc(3);
    chk("t4_w0", img[0], 32'h00000013);
    chk("t4_w1", img[1], 32'h00100093);
    chk("t4_nwr", nWr, 2);

    // start mid-data ignored, then reload from DONE
    w = '{32'hdeadbeef, 32'h12345678};
    mkLoad(w, b);
    nWr = 0;
    pulseStart();
    sendBytes(b, 1'b0, 5);
    waitCyc(3);
    chk("t6_w0", img[0], 32'hdeadbeef);
    chk("t6_w1", img[1], 32'h12345678);
    chk("t6_nwr", nWr, 2);
    pulseStart();
    chk("t6_core_rst_up", 32'(mCoreRst), 1);
    chk("t6_done_down", 32'(mDone), 0);
    sendBytes('{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12},
              1'b0, -1);
    waitCyc(3);
    chk("t6_reload_w0", img[0], 32'h12345678);

    // reset after six data bytes
    w = '{32'ha1a2a3a4, 32'hb1b2b3b4, 32'hc1c2c3c4};
    mkLoad(w, b);
    part = b[0:7];
    nWr = 0;
    pulseStart();
    sendBytes(part, 1'b0, -1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("t5_core_rst", 32'(mCoreRst), 1);
    chk("t5_ready", 32'(mRdy), 0);
    chk("t5_addr", 32'(mAddr), 0);
    rst = 1'b0;
    waitCyc(4);
    chk("t5_nwr", nWr, 1);
    nWr = 0;
    pulseStart();
    sendBytes(b, 1'b0, -1);
    waitCyc(3);
    chk("t5_w0", img[0], 32'ha1a2a3a4);
    chk("t5_w2", img[2], 32'hc1c2c3c4);
    chk("t5_nwr", nWr, 3);

    // four-word memory, five-word image
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk); useB = 1'b1;
    @(negedge clk); rst = 1'b0;
    w = {};
    for (int i = 0; i < 5; i++) w.push_back(32'h01010101 * (i + 1));
    mkLoad(w, b);
    nWr = 0;
    pulseStart();
    sendBytes(b, 1'b0, -1);
    waitCyc(3);
    chk("t3_nwr", nWr, 4);
    chk("t3_wl", 32'(mWl), 4);
    chk("t3_ovf", 32'(mOvf), 1);
    chk("t3_done", 32'(mDone), 1);
    chk("t3_w3", img[3], 32'h04040404);
    chk("t3_addr_sat", 32'(mAddr), 3);

    for (int it = 0; it < 14; it++) begin
      nb = 1'($urandom_range(0, 1));
      if (nb != useB) begin
        @(negedge clk); rst = 1'b1;
        @(negedge clk); @(negedge clk); useB = nb;
        @(negedge clk); rst = 1'b0;
      end
      rc = $urandom_range(0, 6);
      w = {};
      for (int i = 0; i < rc; i++) w.push_back($urandom);
      mkLoad(w, b);
      nWr = 0;
      pulseStart();
      sendBytes(b, 1'b1, -1);
      waitCyc(3);
      dep = useB ? 4 : 1024;
      chk("rnd_nwr", nWr, (rc < dep) ? rc : dep);
      chk("rnd_done", 32'(mDone), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
